// File: rtl/doodle_pkg.sv
// Shared game-level types for the doodle jump datapath: game state encoding,
// BCD digit type and the score ceiling.
package doodle_pkg;

    typedef enum logic [1:0] {
        GS_MENU = 2'd0,
        GS_PLAY = 2'd1,
        GS_OVER = 2'd2,
        GS_RSVD = 2'd3
    } game_state_e;

    typedef logic [3:0] bcd_t;

    localparam int NUM_DIGITS = 4;
    localparam bcd_t [NUM_DIGITS-1:0] MAX_SCORE_BCD = {4'd9, 4'd9, 4'd9, 4'd9};

endpackage

// File: rtl/score_bcd_counter.sv
// Four-digit BCD score counter with collision hold-off, digit-serial ripple
// increment, and high-score capture at game over.
module score_bcd_counter
    import doodle_pkg::*;
#(
    parameter int HOLDOFF_FRAMES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        calculation_time,
    input  logic [1:0]                  game_state,
    input  logic                        move_collision,
    output bcd_t [NUM_DIGITS-1:0]       score_digits,
    output bcd_t [NUM_DIGITS-1:0]       high_digits,
    output logic                        new_high,
    output logic                        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INC,
        S_CMP
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLDOFF_FRAMES - 1);

    // Magnitude compare, most significant digit decides first.
    function automatic logic bcd_gt(input bcd_t [NUM_DIGITS-1:0] a,
                                    input bcd_t [NUM_DIGITS-1:0] b);
        logic gt;
        logic done;
        gt   = 1'b0;
        done = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (!done && a[i] != b[i]) begin
                gt   = a[i] > b[i];
                done = 1'b1;
            end
        end
        return gt;
    endfunction

    state_t     state;
    logic [3:0] holdoff;
    logic       req;
    logic       pending;
    logic       cmp_pend;
    logic [1:0] k;
    logic [1:0] prev_gs;

    logic in_play;
    logic sample;
    logic hit;
    logic play_entry;
    logic over_entry;
    logic at_max;

    assign in_play    = game_state == GS_PLAY;
    assign sample     = calculation_time && in_play;
    assign hit        = sample && move_collision && holdoff == 4'd0;
    assign play_entry = (prev_gs == GS_MENU || prev_gs == GS_RSVD) && in_play;
    assign over_entry = prev_gs == GS_PLAY && game_state == GS_OVER;
    assign at_max     = score_digits == MAX_SCORE_BCD;

    always_ff @(posedge clk) begin
        if (rst) begin
            score_digits <= '0;
            high_digits  <= '0;
            new_high     <= 1'b0;
            busy         <= 1'b0;
            holdoff      <= 4'd0;
            req          <= 1'b0;
            pending      <= 1'b0;
            cmp_pend     <= 1'b0;
            k            <= 2'd0;
            state        <= S_IDLE;
            prev_gs      <= GS_MENU;
        end else begin
            prev_gs  <= game_state;
            new_high <= 1'b0;
            req      <= hit;

            if (hit)
                holdoff <= 4'd1;
            else if (sample && holdoff != 4'd0)
                holdoff <= (holdoff == HOLD_LAST) ? 4'd0 : holdoff + 4'd1;

            if (play_entry) begin
                // New game: wipe the score and abandon any in-flight increment.
                score_digits <= '0;
                holdoff      <= 4'd0;
                req          <= 1'b0;
                pending      <= 1'b0;
                cmp_pend     <= 1'b0;
                k            <= 2'd0;
                state        <= S_IDLE;
                busy         <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cmp_pend || over_entry) begin
                            state    <= S_CMP;
                            cmp_pend <= 1'b0;
                            pending  <= 1'b0;
                        end else if ((req || pending) && in_play) begin
                            if (at_max) begin
                                holdoff <= 4'd0;
                                pending <= 1'b0;
                            end else begin
                                state   <= S_INC;
                                busy    <= 1'b1;
                                k       <= 2'd0;
                                // A fresh request colliding with a served pending one stays queued.
                                pending <= req && pending;
                            end
                        end
                    end
                    S_INC: begin
                        if (req)
                            pending <= 1'b1;
                        if (score_digits[k] == 4'd9) begin
                            score_digits[k] <= 4'd0;
                            k               <= k + 2'd1;
                        end else begin
                            score_digits[k] <= score_digits[k] + 4'd1;
                            state           <= S_IDLE;
                            busy            <= 1'b0;
                        end
                    end
                    S_CMP: begin
                        if (bcd_gt(score_digits, high_digits)) begin
                            high_digits <= score_digits;
                            new_high    <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase

                // Game over mid-increment: finish the digit walk, then compare.
                if (over_entry) begin
                    pending <= 1'b0;
                    if (state != S_IDLE)
                        cmp_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_score_bcd_counter.sv
// Bench for score_bcd_counter: a default-holdoff instance (a) for timing and
// game-flow checks, and a short-holdoff instance (b) to reach saturation.
module tb_score_bcd_counter;
    import doodle_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, cal_a, col_a, nh_a, busy_a;
    logic [1:0] gs_a;
    bcd_t [3:0] sd_a, hd_a;
    logic       rst_b, cal_b, col_b, nh_b, busy_b;
    logic [1:0] gs_b;
    bcd_t [3:0] sd_b, hd_b;

    score_bcd_counter dut_a (
        .clk(clk), .rst(rst_a), .calculation_time(cal_a), .game_state(gs_a),
        .move_collision(col_a), .score_digits(sd_a), .high_digits(hd_a),
        .new_high(nh_a), .busy(busy_a)
    );

    score_bcd_counter #(.HOLDOFF_FRAMES(2)) dut_b (
        .clk(clk), .rst(rst_b), .calculation_time(cal_b), .game_state(gs_b),
        .move_collision(col_b), .score_digits(sd_b), .high_digits(hd_b),
        .new_high(nh_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: plain integers.
    int ma_score = 0, ma_hold = 0, ma_high = 0;
    int mb_score = 0, mb_hold = 0;

    typedef struct {
        logic [1:0] gs;
        logic       cal;
        logic       col;
        int         score;
        logic       busy;
        logic       nh;
        int         high;
    } vec_t;
    vec_t tbl[8];

    int carry_busy[6]  = '{0, 1, 1, 1, 1, 0};
    int carry_score[6] = '{999, 999, 990, 900, 0, 1000};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic int bcd2int(input bcd_t [3:0] d);
        int v;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            if (d[i] > 4'd9) return -1;
            v = v * 10 + int'(d[i]);
        end
        return v;
    endfunction

    // Counting rule: a collision counts only when not in hold-off; hold-off
    // spans h strobes; a count at the ceiling is dropped and ends hold-off.
    task automatic model_strobe(input int h, input bit col, inout int hold, inout int score);
        if (hold == 0) begin
            if (col) begin
                hold = 1;
                if (score < 9999) score++;
                else hold = 0;
            end
        end else begin
            hold = (hold + 1) % h;
        end
    endtask

    task automatic strobe_a(input bit col);
        @(negedge clk);
        cal_a = 1'b1;
        col_a = col;
        @(posedge clk);
        if (gs_a == GS_PLAY) model_strobe(16, col, ma_hold, ma_score);
    endtask

    task automatic quiet_a(input int n);
        repeat (n) begin
            @(negedge clk);
            cal_a = 1'b0;
            col_a = 1'b0;
        end
    endtask

    task automatic fill_a(input int target);
        while (ma_score < target) strobe_a(1'b1);
        while (ma_hold != 0) strobe_a(1'b0);
        quiet_a(8);
    endtask

    task automatic menu_play_a();
        quiet_a(1);
        gs_a = GS_MENU;
        @(negedge clk);
        gs_a = GS_PLAY;
        ma_score = 0;
        ma_hold  = 0;
        quiet_a(1);
    endtask

    task automatic game_over_a(input string name);
        int pulses;
        int exp_p;
        exp_p = (ma_score > ma_high) ? 1 : 0;
        if (exp_p == 1) ma_high = ma_score;
        quiet_a(1);
        gs_a = GS_OVER;
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            pulses += int'(nh_a);
        end
        chk({name, "_pulses"}, pulses, exp_p);
        chk({name, "_high"}, bcd2int(hd_a), ma_high);
    endtask

    task automatic strobe_b(input bit col);
        @(negedge clk);
        cal_b = 1'b1;
        col_b = col;
        @(posedge clk);
        if (gs_b == GS_PLAY) model_strobe(2, col, mb_hold, mb_score);
        @(negedge clk);
        cal_b = 1'b0;
        col_b = 1'b0;
    endtask

    task automatic fill_b(input int target);
        while (mb_score < target) strobe_b(1'b1);
        while (mb_hold != 0) strobe_b(1'b0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{GS_PLAY, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
        tbl[1] = '{GS_PLAY, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0};
        tbl[2] = '{GS_PLAY, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0};
        tbl[3] = '{GS_PLAY, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0};
        tbl[4] = '{GS_PLAY, 1'b1, 1'b1, 1, 1'b0, 1'b0, 0};
        tbl[5] = '{GS_OVER, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0};
        tbl[6] = '{GS_OVER, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1};
        tbl[7] = '{GS_OVER, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1};

        rst_a = 1'b1; cal_a = 1'b0; col_a = 1'b0; gs_a = GS_MENU;
        rst_b = 1'b1; cal_b = 1'b0; col_b = 1'b0; gs_b = GS_MENU;
        repeat (3) @(negedge clk);
        chk("rst_score_a", bcd2int(sd_a), 0);
        chk("rst_high_a", bcd2int(hd_a), 0);
        chk("rst_nh_a", int'(nh_a), 0);
        chk("rst_busy_a", int'(busy_a), 0);
        chk("rst_score_b", bcd2int(sd_b), 0);
        chk("rst_high_b", bcd2int(hd_b), 0);
        chk("rst_nh_b", int'(nh_b), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // First collision latency, hold-off, and game-over compare.
        for (int i = 0; i < 8; i++) begin
            gs_a  = tbl[i].gs;
            cal_a = tbl[i].cal;
            col_a = tbl[i].col;
            @(negedge clk);
            chk($sformatf("tbl%0d_score", i), bcd2int(sd_a), tbl[i].score);
            chk($sformatf("tbl%0d_busy", i), int'(busy_a), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_nh", i), int'(nh_a), int'(tbl[i].nh));
            chk($sformatf("tbl%0d_high", i), bcd2int(hd_a), tbl[i].high);
        end
        cal_a = 1'b0;
        col_a = 1'b0;
        ma_high = 1;

        fork
            begin
                menu_play_a();
                for (int i = 0; i < 300; i++) begin
                    strobe_a(1'($urandom_range(0, 1)));
                    quiet_a(int'($urandom_range(0, 2)));
                    if (i % 60 == 59) begin
                        quiet_a(8);
                        chk("rand_score_a", bcd2int(sd_a), ma_score);
                        chk("rand_busy_a", int'(busy_a), 0);
                    end
                    if (i % 150 == 149) menu_play_a();
                end

                fill_a(999);
                chk("fill_999_a", bcd2int(sd_a), 999);
                strobe_a(1'b1);
                for (int j = 0; j < 6; j++) begin
                    @(negedge clk);
                    cal_a = 1'b0;
                    col_a = 1'b0;
                    chk($sformatf("carry%0d_busy", j), int'(busy_a), carry_busy[j]);
                    chk($sformatf("carry%0d_score", j), bcd2int(sd_a), carry_score[j]);
                end
                repeat (15) strobe_a(1'b1);
                quiet_a(8);
                chk("holdoff_ignored", bcd2int(sd_a), 1000);
                strobe_a(1'b1);
                quiet_a(8);
                chk("holdoff_expired", bcd2int(sd_a), 1001);
                chk("holdoff_model", bcd2int(sd_a), ma_score);

                menu_play_a();
                fill_a(30);
                game_over_a("over30");
                menu_play_a();
                fill_a(42);
                game_over_a("over42");
                chk("high_is_42", bcd2int(hd_a), 42);
                menu_play_a();
                fill_a(42);
                game_over_a("over42_again");

                repeat (3) strobe_a(1'b1);
                quiet_a(8);
                chk("over_hold_score", bcd2int(sd_a), 42);

                menu_play_a();
                fill_a(123);
                game_over_a("over123");
                gs_a = GS_MENU;
                quiet_a(3);
                chk("menu_hold_score", bcd2int(sd_a), 123);
                gs_a = GS_PLAY;
                @(negedge clk);
                ma_score = 0;
                ma_hold  = 0;
                chk("play_entry_score", bcd2int(sd_a), 0);
                chk("play_entry_high", bcd2int(hd_a), 123);
            end
            begin
                @(negedge clk);
                gs_b = GS_PLAY;
                fill_b(999);
                chk("fill_999_b", bcd2int(sd_b), 999);

                // Reset lands in the second increment cycle of the carry walk.
                strobe_b(1'b1);
                @(negedge clk);
                chk("b_inc1_busy", int'(busy_b), 1);
                @(negedge clk);
                chk("b_inc2_busy", int'(busy_b), 1);
                chk("b_inc2_score", bcd2int(sd_b), 990);
                rst_b = 1'b1;
                @(negedge clk);
                rst_b = 1'b0;
                mb_score = 0;
                mb_hold  = 0;
                chk("midrst_score", bcd2int(sd_b), 0);
                chk("midrst_high", bcd2int(hd_b), 0);
                chk("midrst_nh", int'(nh_b), 0);
                chk("midrst_busy", int'(busy_b), 0);
                repeat (4) @(negedge clk);
                chk("postrst_score", bcd2int(sd_b), 0);
                chk("postrst_busy", int'(busy_b), 0);

                fill_b(9999);
                chk("fill_9999_b", bcd2int(sd_b), 9999);
                for (int s = 0; s < 2; s++) begin
                    int busy_seen;
                    strobe_b(1'b1);
                    busy_seen = 0;
                    repeat (6) begin
                        @(negedge clk);
                        busy_seen += int'(busy_b);
                    end
                    chk($sformatf("sat%0d_busy", s), busy_seen, 0);
                    chk($sformatf("sat%0d_score", s), bcd2int(sd_b), 9999);
                end
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
